// File: rtl/exmem_stage_reg_if.sv
// EX/MEM handshake bundle: valid/ready plus control bits and payload of one op.
interface exmem_stage_reg_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  valid;
  logic                  ready;
  logic                  reg_write;
  logic                  mem_write;
  logic                  mem_read;
  logic                  mem_to_reg;
  logic                  mem_src;
  logic                  ret;
  logic [REG_ADDR_W-1:0] dest_reg;
  logic [DATA_W-1:0]     ex;
  logic [DATA_W-1:0]     mem_write_data;

  // Producer side: drives the op, observes ready.
  modport master (
    output valid, reg_write, mem_write, mem_read, mem_to_reg, mem_src, ret,
           dest_reg, ex, mem_write_data,
    input  ready
  );

  // Consumer side: observes the op, drives ready.
  modport slave (
    input  valid, reg_write, mem_write, mem_read, mem_to_reg, mem_src, ret,
           dest_reg, ex, mem_write_data,
    output ready
  );
endinterface

// File: rtl/exmem_stage_reg.sv
// EX/MEM pipeline register with valid/ready flow control, flush and an optional
// skid entry so that MEM back-pressure never reaches EX combinationally.
module exmem_stage_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          SKID       = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  exmem_stage_reg_if.slave   ex_side,
  exmem_stage_reg_if.master  mem_side,
  output logic [1:0]         occupancy
);

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_read;
    logic                  mem_to_reg;
    logic                  mem_src;
    logic                  ret;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic [DATA_W-1:0]     ex;
    logic [DATA_W-1:0]     mem_write_data;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t     state_q;
  entry_t     in_entry;
  entry_t     main_q;
  entry_t     skid_q;
  logic       main_valid_q;
  logic       skid_valid_q;
  logic       in_ready_q;
  logic [1:0] occ_q;
  logic       in_ready;
  logic       accept;
  logic       drain;

  // Keep payload, zero the control bits so an invalid slot looks like a bubble.
  function automatic entry_t bubble(input entry_t e);
    entry_t r;
    r            = e;
    r.reg_write  = 1'b0;
    r.mem_write  = 1'b0;
    r.mem_read   = 1'b0;
    r.mem_to_reg = 1'b0;
    r.mem_src    = 1'b0;
    r.ret        = 1'b0;
    return r;
  endfunction

  // Gather the incoming op into one entry.
  always_comb begin
    in_entry                = '0;
    in_entry.reg_write      = ex_side.reg_write;
    in_entry.mem_write      = ex_side.mem_write;
    in_entry.mem_read       = ex_side.mem_read;
    in_entry.mem_to_reg     = ex_side.mem_to_reg;
    in_entry.mem_src        = ex_side.mem_src;
    in_entry.ret            = ex_side.ret;
    in_entry.dest_reg       = ex_side.dest_reg;
    in_entry.ex             = ex_side.ex;
    in_entry.mem_write_data = ex_side.mem_write_data;
  end

  // With a skid slot ready is a flop; without one it must look through to MEM.
  assign in_ready = SKID ? in_ready_q : (!main_valid_q || mem_side.ready);
  assign accept   = ex_side.valid && in_ready;
  assign drain    = main_valid_q && mem_side.ready;

  // Occupancy FSM: main slot feeds MEM, skid slot only ever refills main (strict FIFO).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      in_ready_q   <= 1'b1;
      occ_q        <= 2'd0;
    end else if (flush) begin
      state_q      <= EMPTY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= bubble(main_q);
      skid_q       <= bubble(skid_q);
      in_ready_q   <= 1'b1;
      occ_q        <= 2'd0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q       <= in_entry;
            main_valid_q <= 1'b1;
            occ_q        <= 2'd1;
            state_q      <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_q <= in_entry;
          end else if (accept && SKID) begin
            skid_q       <= in_entry;
            skid_valid_q <= 1'b1;
            in_ready_q   <= 1'b0;
            occ_q        <= 2'd2;
            state_q      <= TWO;
          end else if (drain) begin
            main_q       <= bubble(main_q);
            main_valid_q <= 1'b0;
            occ_q        <= 2'd0;
            state_q      <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            main_q       <= skid_q;
            skid_q       <= bubble(skid_q);
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            occ_q        <= 2'd1;
            state_q      <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign ex_side.ready           = in_ready;
  assign mem_side.valid          = main_valid_q;
  assign mem_side.reg_write      = main_q.reg_write;
  assign mem_side.mem_write      = main_q.mem_write;
  assign mem_side.mem_read       = main_q.mem_read;
  assign mem_side.mem_to_reg     = main_q.mem_to_reg;
  assign mem_side.mem_src        = main_q.mem_src;
  assign mem_side.ret            = main_q.ret;
  assign mem_side.dest_reg       = main_q.dest_reg;
  assign mem_side.ex             = main_q.ex;
  assign mem_side.mem_write_data = main_q.mem_write_data;
  assign occupancy               = occ_q;

endmodule

// File: tb/tb_exmem_stage_reg.sv
// Bench for exmem_stage_reg: vector table on a skid build plus a scoreboard of
// accepted ops, and a hand sequence on a single-entry build.
module tb_exmem_stage_reg;

  logic       clk = 1'b0;
  logic       rst1, flush1, rst0, flush0;
  logic [1:0] occ1, occ0;

  exmem_stage_reg_if #(.DATA_W(32), .REG_ADDR_W(5)) ex1 ();
  exmem_stage_reg_if #(.DATA_W(32), .REG_ADDR_W(5)) mem1 ();
  exmem_stage_reg_if #(.DATA_W(32), .REG_ADDR_W(5)) ex0 ();
  exmem_stage_reg_if #(.DATA_W(32), .REG_ADDR_W(5)) mem0 ();

  exmem_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .flush(flush1),
    .ex_side(ex1), .mem_side(mem1), .occupancy(occ1)
  );

  exmem_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .flush(flush0),
    .ex_side(ex0), .mem_side(mem0), .occupancy(occ0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, iv;
    logic [31:0] ex;
    logic        rw, mw, ordy;
    logic        e_valid, e_rdy;
    logic [1:0]  e_occ;
    logic        chk_ex;
    logic [31:0] e_ex;
    logic        e_rw, e_mw;
  } vec_t;

  localparam int NV = 22;
  vec_t        vecs [NV];
  logic [31:0] sb [$];
  int          tests = 0;
  int          failed = 0;

  function automatic vec_t mk(input logic r, f, iv, input logic [31:0] ex,
                              input logic rw, mw, ordy, ev, erdy,
                              input logic [1:0] eocc, input logic cex,
                              input logic [31:0] eex, input logic erw, emw);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.ex = ex; v.rw = rw; v.mw = mw;
    v.ordy = ordy; v.e_valid = ev; v.e_rdy = erdy; v.e_occ = eocc;
    v.chk_ex = cex; v.e_ex = eex; v.e_rw = erw; v.e_mw = emw;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive1(input vec_t v);
    rst1 = v.rst; flush1 = v.flush;
    ex1.valid = v.iv; ex1.ex = v.ex; ex1.reg_write = v.rw; ex1.mem_write = v.mw;
    ex1.mem_read = 1'b0; ex1.mem_to_reg = v.rw; ex1.mem_src = v.mw; ex1.ret = 1'b0;
    ex1.dest_reg = v.ex[4:0]; ex1.mem_write_data = ~v.ex;
    mem1.ready = v.ordy;
  endtask

  task automatic drive0(input logic iv, input logic [31:0] ex, input logic ordy);
    ex0.valid = iv; ex0.ex = ex; ex0.reg_write = iv; ex0.mem_write = 1'b0;
    ex0.mem_read = 1'b0; ex0.mem_to_reg = 1'b0; ex0.mem_src = 1'b0; ex0.ret = 1'b0;
    ex0.dest_reg = ex[4:0]; ex0.mem_write_data = ex;
    mem0.ready = ordy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //                 rst fl iv ex      rw mw or | v rdy occ chk ex      rw mw
    vecs[0]  = mk(1, 0, 1, 32'h99, 1, 1, 0,  0, 1, 2'd0, 1, 32'h0,  0, 0);
    vecs[1]  = mk(1, 0, 1, 32'h99, 1, 1, 0,  0, 1, 2'd0, 1, 32'h0,  0, 0);
    vecs[2]  = mk(0, 0, 1, 32'h10, 1, 0, 1,  1, 1, 2'd1, 1, 32'h10, 1, 0);
    vecs[3]  = mk(0, 0, 1, 32'h20, 1, 0, 1,  1, 1, 2'd1, 1, 32'h20, 1, 0);
    vecs[4]  = mk(0, 0, 1, 32'h30, 1, 0, 1,  1, 1, 2'd1, 1, 32'h30, 1, 0);
    vecs[5]  = mk(0, 0, 0, 32'h0,  0, 0, 1,  0, 1, 2'd0, 1, 32'h30, 0, 0);
    vecs[6]  = mk(0, 0, 1, 32'hA,  1, 0, 0,  1, 1, 2'd1, 1, 32'hA,  1, 0);
    vecs[7]  = mk(0, 0, 1, 32'hB,  0, 0, 0,  1, 0, 2'd2, 1, 32'hA,  1, 0);
    vecs[8]  = mk(0, 0, 1, 32'hEE, 1, 1, 0,  1, 0, 2'd2, 1, 32'hA,  1, 0);
    vecs[9]  = mk(0, 0, 0, 32'h0,  0, 0, 1,  1, 1, 2'd1, 1, 32'hB,  0, 0);
    vecs[10] = mk(0, 0, 0, 32'h0,  0, 0, 1,  0, 1, 2'd0, 1, 32'hB,  0, 0);
    vecs[11] = mk(0, 0, 1, 32'h1,  0, 1, 0,  1, 1, 2'd1, 1, 32'h1,  0, 1);
    vecs[12] = mk(0, 0, 1, 32'h2,  0, 1, 0,  1, 0, 2'd2, 1, 32'h1,  0, 1);
    vecs[13] = mk(0, 1, 1, 32'hC,  0, 1, 0,  0, 1, 2'd0, 0, 32'h0,  0, 0);
    vecs[14] = mk(0, 0, 0, 32'h0,  0, 0, 1,  0, 1, 2'd0, 1, 32'h1,  0, 0);
    vecs[15] = mk(0, 0, 1, 32'h4,  0, 0, 0,  1, 1, 2'd1, 1, 32'h4,  0, 0);
    vecs[16] = mk(0, 0, 1, 32'h5,  0, 0, 1,  1, 1, 2'd1, 1, 32'h5,  0, 0);
    vecs[17] = mk(0, 0, 0, 32'h0,  0, 0, 1,  0, 1, 2'd0, 1, 32'h5,  0, 0);
    vecs[18] = mk(0, 0, 1, 32'h7,  1, 0, 0,  1, 1, 2'd1, 1, 32'h7,  1, 0);
    vecs[19] = mk(0, 1, 1, 32'h8,  1, 0, 1,  0, 1, 2'd0, 1, 32'h7,  0, 0);
    vecs[20] = mk(0, 0, 1, 32'h9,  1, 1, 0,  1, 1, 2'd1, 1, 32'h9,  1, 1);
    vecs[21] = mk(1, 1, 1, 32'h9,  1, 1, 1,  0, 1, 2'd0, 1, 32'h0,  0, 0);

    drive1(vecs[0]);
    rst0 = 1'b1; flush0 = 1'b0;
    drive0(1'b1, 32'h0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive1(vecs[i]);
      #1;
      // Scoreboard: drains pop in order, accepts push; reset/flush discard everything.
      if (vecs[i].rst || vecs[i].flush) begin
        sb.delete();
      end else begin
        if (mem1.valid && mem1.ready) begin
          if (sb.size() == 0) begin
            check($sformatf("sb_unexpected_drain[%0d]", i), mem1.ex, 32'hFFFF_FFFF);
          end else begin
            check($sformatf("sb_order[%0d]", i), mem1.ex, sb.pop_front());
          end
        end
        if (ex1.valid && ex1.ready) sb.push_back(ex1.ex);
      end
      @(posedge clk);
      #1;
      check($sformatf("out_valid[%0d]", i), 32'(mem1.valid), 32'(vecs[i].e_valid));
      check($sformatf("in_ready[%0d]", i), 32'(ex1.ready), 32'(vecs[i].e_rdy));
      check($sformatf("occupancy[%0d]", i), 32'(occ1), 32'(vecs[i].e_occ));
      check($sformatf("reg_write_out[%0d]", i), 32'(mem1.reg_write), 32'(vecs[i].e_rw));
      check($sformatf("mem_write_out[%0d]", i), 32'(mem1.mem_write), 32'(vecs[i].e_mw));
      if (vecs[i].chk_ex) check($sformatf("ex_out[%0d]", i), mem1.ex, vecs[i].e_ex);
      if (i == 1 || i == 21) begin
        check($sformatf("rst_dest[%0d]", i), 32'(mem1.dest_reg), 32'h0);
        check($sformatf("rst_mwdata[%0d]", i), mem1.mem_write_data, 32'h0);
        check($sformatf("rst_ctrl[%0d]", i),
              32'({mem1.mem_read, mem1.mem_to_reg, mem1.mem_src, mem1.ret}), 32'h0);
      end
      if (i == 5) begin
        check("hold_dest", 32'(mem1.dest_reg), 32'h10);
        check("hold_mwdata", mem1.mem_write_data, ~32'h30);
        check("bubble_ctrl", 32'({mem1.mem_to_reg, mem1.mem_src}), 32'h0);
      end
    end
    check("sb_empty", 32'(sb.size()), 32'h0);

    // Single-entry build: ready follows MEM in the same cycle.
    @(negedge clk);
    rst0 = 1'b0;
    check("s0_rst_occ", 32'(occ0), 32'h0);
    check("s0_rst_valid", 32'(mem0.valid), 32'h0);
    drive0(1'b1, 32'h40, 1'b0);
    #1;
    check("s0_ready_empty", 32'(ex0.ready), 32'h1);
    @(posedge clk); #1;
    check("s0_load_ex", mem0.ex, 32'h40);
    check("s0_load_occ", 32'(occ0), 32'h1);
    @(negedge clk);
    drive0(1'b1, 32'h41, 1'b0);
    #1;
    check("s0_ready_stall", 32'(ex0.ready), 32'h0);
    @(posedge clk); #1;
    check("s0_stall_hold", mem0.ex, 32'h40);
    @(negedge clk);
    drive0(1'b1, 32'h41, 1'b1);
    #1;
    check("s0_ready_release", 32'(ex0.ready), 32'h1);
    @(posedge clk); #1;
    check("s0_b2b_ex1", mem0.ex, 32'h41);
    check("s0_b2b_occ", 32'(occ0), 32'h1);
    @(negedge clk);
    drive0(1'b1, 32'h42, 1'b1);
    @(posedge clk); #1;
    check("s0_b2b_ex2", mem0.ex, 32'h42);
    @(negedge clk);
    drive0(1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    check("s0_drain_valid", 32'(mem0.valid), 32'h0);
    check("s0_drain_occ", 32'(occ0), 32'h0);
    check("s0_drain_rw", 32'(mem0.reg_write), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
